// File: rtl/pong_pkg.sv
// Shared screen geometry and pixel word layout for the pong video path.
package pong_pkg;

    localparam int X_SCREEN_PIXELS = 320;
    localparam int Y_SCREEN_PIXELS = 240;
    localparam int XW              = $clog2(X_SCREEN_PIXELS) + 1;
    localparam int YW              = $clog2(Y_SCREEN_PIXELS) + 1;
    localparam int CW              = 3;
    localparam int PW              = XW + YW + CW;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
    } pixel_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    function automatic logic in_screen(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < XW'(X_SCREEN_PIXELS)) && (y < YW'(Y_SCREEN_PIXELS));
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Per-source pixel buffer; head entry is visible combinationally on o_rdata.
module pixel_fifo #(
    parameter int PW         = 22,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [PW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [PW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [PW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_pop;
    logic          w_do_push;

    // A full FIFO still takes a write when its head leaves in the same cycle
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array write port
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Read/write pointer advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/pixel_arbiter.sv
// Merges the two paddle-drawer pixel streams into one VGA pixel port with
// per-source buffering, round-robin draining and frame-done detection.
module pixel_arbiter
    import pong_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic          iClock,
    input  logic          iResetn,
    input  logic [XW-1:0] iX0,
    input  logic [YW-1:0] iY0,
    input  logic [CW-1:0] iColour0,
    input  logic          iPlot0,
    input  logic          iNewFrame0,
    input  logic [XW-1:0] iX1,
    input  logic [YW-1:0] iY1,
    input  logic [CW-1:0] iColour1,
    input  logic          iPlot1,
    input  logic          iNewFrame1,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic [CW-1:0] oColour,
    output logic          oPlot,
    output logic          oFrameDone,
    output logic [1:0]    oOverflow
);

    pixel_t        w_pix0;
    pixel_t        w_pix1;
    pixel_t        w_head0;
    pixel_t        w_head1;
    pixel_t        w_head_sel;
    logic          w_valid0;
    logic          w_valid1;
    logic          w_full0;
    logic          w_full1;
    logic          w_empty0;
    logic          w_empty1;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_any_grant;
    logic          w_push0;
    logic          w_push1;
    logic          w_drop0;
    logic          w_drop1;
    logic          w_frame_done;

    src_e          r_last;
    logic          r_flag0;
    logic          r_flag1;
    logic          r_plot;
    logic          r_frame_done;
    logic [1:0]    r_overflow;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_colour;

    assign w_pix0   = '{x: iX0, y: iY0, colour: iColour0};
    assign w_pix1   = '{x: iX1, y: iY1, colour: iColour1};
    assign w_valid0 = iPlot0 & in_screen(iX0, iY0);
    assign w_valid1 = iPlot1 & in_screen(iX1, iY1);

    assign w_push0 = w_valid0 & (~w_full0 | w_grant0);
    assign w_push1 = w_valid1 & (~w_full1 | w_grant1);
    assign w_drop0 = w_valid0 & w_full0 & ~w_grant0;
    assign w_drop1 = w_valid1 & w_full1 & ~w_grant1;

    pixel_fifo #(.PW(PW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
        .i_clk   (iClock),
        .i_rst_n (iResetn),
        .i_push  (w_push0),
        .i_wdata (w_pix0),
        .i_pop   (w_grant0),
        .o_rdata (w_head0),
        .o_full  (w_full0),
        .o_empty (w_empty0)
    );

    pixel_fifo #(.PW(PW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
        .i_clk   (iClock),
        .i_rst_n (iResetn),
        .i_push  (w_push1),
        .i_wdata (w_pix1),
        .i_pop   (w_grant1),
        .o_rdata (w_head1),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

    // Round-robin grant: on contention serve the source not granted last
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        case ({w_empty1, w_empty0})
            2'b00: begin
                if (r_last == SRC0) begin
                    w_grant1 = 1'b1;
                end else begin
                    w_grant0 = 1'b1;
                end
            end
            2'b01:   w_grant1 = 1'b1;
            2'b10:   w_grant0 = 1'b1;
            default: begin
                w_grant0 = 1'b0;
                w_grant1 = 1'b0;
            end
        endcase
    end

    assign w_any_grant  = w_grant0 | w_grant1;
    assign w_head_sel   = w_grant1 ? w_head1 : w_head0;
    assign w_frame_done = r_flag0 & r_flag1 & w_empty0 & w_empty1 & ~w_any_grant;

    // Output pixel register, RR pointer and sticky overflow flags
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_plot     <= 1'b0;
            r_x        <= {XW{1'b0}};
            r_y        <= {YW{1'b0}};
            r_colour   <= {CW{1'b0}};
            r_last     <= SRC0;
            r_overflow <= 2'b00;
        end else begin
            r_plot     <= w_any_grant;
            r_overflow <= r_overflow | {w_drop1, w_drop0};
            if (w_any_grant) begin
                r_x      <= w_head_sel.x;
                r_y      <= w_head_sel.y;
                r_colour <= w_head_sel.colour;
                r_last   <= w_grant1 ? SRC1 : SRC0;
            end
        end
    end

    // Frame flags; a fresh end-of-frame pulse beats the clear
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_flag0      <= 1'b0;
            r_flag1      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_flag0      <= iNewFrame0 | (r_flag0 & ~w_frame_done);
            r_flag1      <= iNewFrame1 | (r_flag1 & ~w_frame_done);
            r_frame_done <= w_frame_done;
        end
    end

    assign oX         = r_x;
    assign oY         = r_y;
    assign oColour    = r_colour;
    assign oPlot      = r_plot;
    assign oFrameDone = r_frame_done;
    assign oOverflow  = r_overflow;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Scoreboard bench for pixel_arbiter: stimulus queues expected pixels, a
// negedge monitor pops and compares every oPlot.
module tb_pixel_arbiter;
    import pong_pkg::*;

    logic          clk = 1'b0;
    logic          iResetn;
    logic [XW-1:0] iX0, iX1, oX;
    logic [YW-1:0] iY0, iY1, oY;
    logic [CW-1:0] iColour0, iColour1, oColour;
    logic          iPlot0, iPlot1, iNewFrame0, iNewFrame1;
    logic          oPlot, oFrameDone;
    logic [1:0]    oOverflow;

    pixel_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_plot_cyc = -100;
    int done_cyc = -100;
    int done_cnt = 0;

    always #5 clk = ~clk;

    pixel_arbiter dut (
        .iClock(clk), .iResetn(iResetn),
        .iX0(iX0), .iY0(iY0), .iColour0(iColour0), .iPlot0(iPlot0), .iNewFrame0(iNewFrame0),
        .iX1(iX1), .iY1(iY1), .iColour1(iColour1), .iPlot1(iPlot1), .iNewFrame1(iNewFrame1),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
        .oFrameDone(oFrameDone), .oOverflow(oOverflow)
    );

    function automatic pixel_t mk(input int x, input int y, input int c);
        pixel_t p;
        p.x = XW'(x);
        p.y = YW'(y);
        p.colour = CW'(c);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        iPlot0 = 1'b0; iPlot1 = 1'b0; iNewFrame0 = 1'b0; iNewFrame1 = 1'b0;
    endtask

    task automatic drive0(input pixel_t p);
        iX0 = p.x; iY0 = p.y; iColour0 = p.colour; iPlot0 = 1'b1;
    endtask

    task automatic drive1(input pixel_t p);
        iX1 = p.x; iY1 = p.y; iColour1 = p.colour; iPlot1 = 1'b1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            step();
            t++;
        end
        repeat (4) step();
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compare every presented pixel against the scoreboard head
    initial begin
        pixel_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (oPlot === 1'b1) begin
                last_plot_cyc = cyc;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot", oX, oY, oColour);
                end else begin
                    e = exp_q.pop_front();
                    if ({oX, oY, oColour} !== e) begin
                        n_err++;
                        $display("FAIL pixel: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                                 oX, oY, oColour, e.x, e.y, e.colour);
                    end
                end
            end
            if (oFrameDone === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pixel_t s0[$];
        pixel_t s1[$];
        iResetn = 1'b0;
        iX0 = '0; iY0 = '0; iColour0 = '0; iX1 = '0; iY1 = '0; iColour1 = '0;
        clr_in();
        repeat (3) step();
        check("reset_plot", oPlot, 0);
        check("reset_outs", {oX, oY, oColour, oFrameDone, oOverflow}, 0);
        iResetn = 1'b1;
        repeat (3) step();
        check("idle_plot", oPlot, 0);

        // Single source, 2-cycle latency
        drive0(mk(5, 20, 7));
        exp_q.push_back(mk(5, 20, 7));
        step();
        clr_in();
        check("t1_lat1_plot", oPlot, 0);
        step();
        check("t1_lat2_plot", oPlot, 1);
        check("t1_xyc", {oX, oY, oColour}, mk(5, 20, 7));
        check("t1_ovf", oOverflow, 0);
        drain("t1_drain");

        // Lone source 1 pixel; leaves RR pointer on source 1
        drive1(mk(7, 8, 3));
        exp_q.push_back(mk(7, 8, 3));
        step();
        clr_in();
        drain("t1b_drain");

        // Contention: strict alternation starting at source 0
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(30 + i, 60 + i, i));
            exp_q.push_back(mk(130 + i, 160 + i, 7 - i));
            drive0(mk(30 + i, 60 + i, i));
            drive1(mk(130 + i, 160 + i, 7 - i));
            step();
        end
        clr_in();
        drain("t2_drain");

        // Range: out-of-screen pixels vanish; boundary pixel passes
        drive0(mk(320, 10, 1));
        drive1(mk(10, 240, 2));
        step();
        clr_in();
        drive1(mk(319, 239, 6));
        exp_q.push_back(mk(319, 239, 6));
        step();
        clr_in();
        drain("t4_drain");
        check("t4_ovf", oOverflow, 0);

        // Overflow: src1 drops k=31,33; src0 drops k=32
        for (int k = 0; k < 34; k++) begin
            if (k != 32) s0.push_back(mk(k, 100, 1));
            if (k != 31 && k != 33) s1.push_back(mk(200 + k, 50, 2));
        end
        for (int i = 0; i < 33; i++) begin
            exp_q.push_back(s0[i]);
            if (i < 32) exp_q.push_back(s1[i]);
        end
        for (int k = 0; k < 34; k++) begin
            drive0(mk(k, 100, 1));
            drive1(mk(200 + k, 50, 2));
            step();
            if (k == 30) check("t3_ovf_k30", oOverflow, 2'b00);
            if (k == 31) check("t3_ovf_k31", oOverflow, 2'b10);
        end
        clr_in();
        check("t3_ovf_end", oOverflow, 2'b11);
        drain("t3_drain");
        check("t3_no_done", done_cnt, 0);

        // Frame done: one pulse right after the last buffered pixel
        iNewFrame0 = 1'b1;
        drive0(mk(11, 11, 1));
        drive1(mk(21, 21, 2));
        exp_q.push_back(mk(21, 21, 2));
        exp_q.push_back(mk(11, 11, 1));
        step();
        clr_in();
        drive0(mk(12, 12, 3));
        drive1(mk(22, 22, 4));
        exp_q.push_back(mk(22, 22, 4));
        exp_q.push_back(mk(12, 12, 3));
        step();
        clr_in();
        step();
        iNewFrame1 = 1'b1;
        step();
        clr_in();
        drain("t5_drain");
        check("t5_done_cnt", done_cnt, 1);
        check("t5_done_gap", done_cyc - last_plot_cyc, 1);

        // Reset with 6 pixels buffered
        exp_q.push_back(mk(140, 80, 4));
        exp_q.push_back(mk(40, 70, 3));
        exp_q.push_back(mk(141, 80, 4));
        for (int k = 0; k < 5; k++) begin
            drive0(mk(40 + k, 70, 3));
            drive1(mk(140 + k, 80, 4));
            step();
        end
        clr_in();
        iResetn = 1'b0;
        #1;
        check("t6_rst_plot", oPlot, 0);
        step();
        check("t6_consumed", exp_q.size(), 0);
        iResetn = 1'b1;
        repeat (30) step();
        check("t6_ovf", oOverflow, 0);
        check("t6_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
